vid_rgbout: RTL
===============

# vid_rgbout

Video output stage directly downstream of the CRY-to-RGB converter. It registers the converted 8:8:8 pixel on each pixel enable. It delays the raw sync/blank timing so it lines up with the converter's pixel latency, and forces black outside active video. It also tracks pixel and line positions, so scan-out and test logic can read the measured line length and a frame strobe.

## Interface
Parameters:
- SYNC_DLY, 2, number of vclk enables by which hs/vs/blank are delayed relative to their sampling point; legal range 1..4.
- PIX_W, 11, width of pixel counters (saturating).
- LINE_W, 10, width of line counter (saturating).

Ports:
- sys_clk  in  1  system clock; all state changes on rising edge.
- resetl  in  1  asynchronous, active-low reset.
- vclk  in  1  pixel enable, one sys_clk wide, synchronous to sys_clk; all pixel-rate state advances only when vclk=1.
- r_in, g_in, b_in  in  8 each  pixel from CRY-to-RGB converter.
- hs_in, vs_in  in  1 each  raw horizontal/vertical sync, active high, aligned with the CRY word feeding the converter.
- blank_in  in  1  raw blanking, active high, same alignment as syncs.
- r_out, g_out, b_out  out  8 each  output pixel.
- hs_out, vs_out  out  1 each  aligned syncs.
- de_out  out  1  data enable (= delayed !blank).
- pix_cnt  out  PIX_W  position of current pixel within active line.
- line_cnt  out  LINE_W  active lines since last vsync.
- line_len  out  PIX_W  active pixel count of the last completed line.
- frame_stb  out  1  one-sys_clk pulse on vs_out rising.

## Operation
- Sync pipeline: {hs_in, vs_in, blank_in} enter a SYNC_DLY-deep shift register, advanced only on vclk; the tail feeds the output registers.
- Pixel register: on vclk, r/g/b_out take r/g/b_in when the delayed blank=0, else 0.
- de_out is registered on the same vclk and equals !blank at the pipeline tail.
- Line tracker FSM (advances on vclk):
  - States: VSYNC, WAIT_DE, ACTIVE, HBLANK.
  - VSYNC→WAIT_DE when vs at tail=0.
  - WAIT_DE/HBLANK→ACTIVE when de becomes 1.
  - ACTIVE→HBLANK when de becomes 0.
  - Any state→VSYNC on vs tail rising.
- Counter behaviour by FSM state:
  - ACTIVE: pix_cnt increments per vclk; saturates at 2^PIX_W−1.
  - ACTIVE→HBLANK: line_len ← pix_cnt+1 (saturating); pix_cnt←0; line_cnt increments, saturating.
- On vs tail rising: line_cnt←0, pix_cnt←0, frame_stb=1 for one sys_clk.
- Simultaneous vs rising and de falling: line_len is still latched, and line_cnt ends at 0 (vsync wins).
- Reset mid-line: all state is cleared immediately; the next line is measured from the first full de rising after vs.

## Timing
- Reset values: all outputs 0; FSM=VSYNC; pipeline cleared to 0, so the blank tail decodes to de=0 until filled (the reset value of blank is treated as blanked).
- Pixel latency: a pixel sampled at vclk n appears on r/g/b_out one sys_clk after that edge.
- Sync latency: hs/vs/blank sampled at vclk n reach hs/vs/de_out after vclk n+SYNC_DLY. The default of 2 covers the converter's one-enable latency plus this stage's register.
- No output changes without vclk, except frame_stb deassertion.
- Counters and line_len update in the same sys_clk as de_out changes.

## Configuration
- RGBOUT_DITHER_EN defined:
  - Each active pixel component gets a 2x2 ordered-dither offset added, with saturation at 255. The offset is {0,2,3,1} indexed by {line_cnt[0], pix_cnt[0]}.
  - The low 2 bits of each component are then zeroed, for 6-bit panels.
  - Black in blanking is unaffected.
- Undefined: pixels pass through unmodified; no dither logic is built.

## Structure
- Shared package holds:
  - the FSM state enum (VSYNC, WAIT_DE, ACTIVE, HBLANK);
  - the dither offset constant table;
  - default PIX_W/LINE_W.
- One sub-module, vid_syncdly: the parameterised enable-gated SYNC_DLY shift register for {hs, vs, blank}.
- The rest stays flat in vid_rgbout.

## Test plan
- Reset asserted mid-line with vclk running → all outputs 0 immediately; after release the first measured line_len equals the true active width, e.g. 320.
- 320 active pixels per line, vclk every 2nd sys_clk, SYNC_DLY=2 → de_out asserts exactly 2 vclk after blank_in falls; line_len=320; line_cnt increments once per line.
- Blank_in=1 with r/g/b_in=0xFF → r/g/b_out=0.
- vs_in pulse → frame_stb high for exactly one sys_clk, 2 vclk later; line_cnt=0.
- vs rising coincident with de falling → line_len latched, line_cnt=0.
- Active line of 3000 pixels → pix_cnt and line_len saturate at 2047.
- RGBOUT_DITHER_EN: constant input 0xFE → outputs 0xFC and 0xFC on line 0 for pixels 0 and 1 (0xFE+0=0xFE and 0xFE+2=0x100 saturating to 0xFF, both masked to 0xFC); 0x41 → 0x40 or 0x44 per the Bayer position.

Source files
------------

// File: rtl/vid_rgbout_pkg.sv
// Shared types and constants for the video output stage.
// Holds the line tracker state enum, the 2x2 ordered-dither table and default counter widths.
// No logic of its own; the dither helper only builds hardware where it is called.
package vid_rgbout_pkg;

  localparam int PIX_W_DEF  = 11;
  localparam int LINE_W_DEF = 10;

  typedef enum logic [1:0] {
    VSYNC   = 2'd0,
    WAIT_DE = 2'd1,
    ACTIVE  = 2'd2,
    HBLANK  = 2'd3
  } lt_state_t;

  // Ordered-dither offsets indexed by {line parity, pixel parity}: 0,2,3,1
  localparam logic [3:0][1:0] DITHER_TBL = {2'd1, 2'd3, 2'd2, 2'd0};

  // Add the positional offset with saturation at 255, then drop to 6 significant bits
  function automatic logic [7:0] dither_px(input logic [7:0] px,
                                           input logic       line0,
                                           input logic       pix0);
    logic [8:0] sum;
    logic [7:0] sat;
    sum = {1'b0, px} + {7'd0, DITHER_TBL[{line0, pix0}]};
    sat = sum[8] ? 8'hFF : sum[7:0];
    return sat & 8'hFC;
  endfunction

endpackage

// File: rtl/vid_syncdly.sv
// Enable-gated shift register that delays the raw timing bits by DLY pixel enables.
// Latency: DLY enables from i_dat to o_dat; state only moves when i_vclk=1.
// No backpressure: the pixel enable is the only flow control.
module vid_syncdly #(
  parameter int DLY = 2,
  parameter int W   = 3
) (
  input  logic         i_sys_clk,
  input  logic         i_resetl,
  input  logic         i_vclk,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat
);

  logic [W-1:0] r_pipe [DLY];

  // Shift one stage per pixel enable; reset clears every stage
  always_ff @(posedge i_sys_clk or negedge i_resetl) begin
    if (!i_resetl) begin
      for (int i = 0; i < DLY; i++) r_pipe[i] <= '0;
    end else if (i_vclk) begin
      r_pipe[0] <= i_dat;
      for (int i = 1; i < DLY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_dat = r_pipe[DLY-1];

endmodule

// File: rtl/vid_rgbout.sv
// Video output stage: registers the RGB pixel, aligns sync/blank, tracks pixel/line positions.
// Latency: pixel 1 enable, syncs SYNC_DLY enables; optional dither under RGBOUT_DITHER_EN.
// No backpressure: everything advances on the vclk pixel enable only.
module vid_rgbout
  import vid_rgbout_pkg::*;
#(
  parameter int SYNC_DLY = 2,
  parameter int PIX_W    = PIX_W_DEF,
  parameter int LINE_W   = LINE_W_DEF
) (
  input  logic              sys_clk,
  input  logic              resetl,
  input  logic              vclk,
  input  logic [7:0]        r_in,
  input  logic [7:0]        g_in,
  input  logic [7:0]        b_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              blank_in,
  output logic [7:0]        r_out,
  output logic [7:0]        g_out,
  output logic [7:0]        b_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic              de_out,
  output logic [PIX_W-1:0]  pix_cnt,
  output logic [LINE_W-1:0] line_cnt,
  output logic [PIX_W-1:0]  line_len,
  output logic              frame_stb
);

  // Blank is carried inverted (as de) so the cleared pipeline reads as blanked
  logic [2:0]        w_tail;
  logic              w_tail_hs, w_tail_vs, w_tail_de;
  logic              w_vs_rise, w_de_rise;
  logic [PIX_W-1:0]  w_pix_inc;
  logic [LINE_W-1:0] w_line_inc;
  logic [7:0]        w_r, w_g, w_b;
  lt_state_t         r_state, w_state_nxt;

  logic [7:0]        r_red, r_grn, r_blu;
  logic              r_hs, r_vs, r_de, r_stb;
  logic [PIX_W-1:0]  r_pix, r_len;
  logic [LINE_W-1:0] r_line;

  vid_syncdly #(.DLY(SYNC_DLY), .W(3)) u_syncdly (
    .i_sys_clk (sys_clk),
    .i_resetl  (resetl),
    .i_vclk    (vclk),
    .i_dat     ({hs_in, vs_in, ~blank_in}),
    .o_dat     (w_tail)
  );

  assign {w_tail_hs, w_tail_vs, w_tail_de} = w_tail;
  assign w_vs_rise  = w_tail_vs & ~r_vs;
  assign w_de_rise  = w_tail_de & ~r_de;
  assign w_pix_inc  = (r_pix  == '1) ? r_pix  : r_pix  + 1'b1;
  assign w_line_inc = (r_line == '1) ? r_line : r_line + 1'b1;

`ifdef RGBOUT_DITHER_EN
  // Position of the pixel being loaded now: 0 on line start, else the next count
  logic w_pos0;
  assign w_pos0 = (r_state == ACTIVE) ? w_pix_inc[0] : 1'b0;
  assign w_r = dither_px(r_in, r_line[0], w_pos0);
  assign w_g = dither_px(g_in, r_line[0], w_pos0);
  assign w_b = dither_px(b_in, r_line[0], w_pos0);
`else
  assign w_r = r_in;
  assign w_g = g_in;
  assign w_b = b_in;
`endif

  // Line tracker next state; a vsync rising edge overrides everything
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      VSYNC:           if (!w_tail_vs) w_state_nxt = WAIT_DE;
      WAIT_DE, HBLANK: if (w_de_rise)  w_state_nxt = ACTIVE;
      ACTIVE:          if (!w_tail_de) w_state_nxt = HBLANK;
    endcase
    if (w_vs_rise) w_state_nxt = VSYNC;
  end

  // Line tracker state register, advanced per pixel enable
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl)   r_state <= VSYNC;
    else if (vclk) r_state <= w_state_nxt;
  end

  // Output pixel and aligned timing; black whenever the tail says blanked
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      {r_red, r_grn, r_blu} <= '0;
      {r_hs, r_vs, r_de}    <= '0;
    end else if (vclk) begin
      r_hs <= w_tail_hs;
      r_vs <= w_tail_vs;
      r_de <= w_tail_de;
      if (w_tail_de) {r_red, r_grn, r_blu} <= {w_r, w_g, w_b};
      else           {r_red, r_grn, r_blu} <= '0;
    end
  end

  // Position counters and frame strobe; vsync clears after a line end latches its length
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_pix  <= '0;
      r_line <= '0;
      r_len  <= '0;
      r_stb  <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      if (vclk) begin
        if (r_state == ACTIVE) begin
          if (w_tail_de) begin
            r_pix <= w_pix_inc;
          end else begin
            r_len  <= w_pix_inc;
            r_pix  <= '0;
            r_line <= w_line_inc;
          end
        end
        if (w_vs_rise) begin
          r_pix  <= '0;
          r_line <= '0;
          r_stb  <= 1'b1;
        end
      end
    end
  end

  assign r_out     = r_red;
  assign g_out     = r_grn;
  assign b_out     = r_blu;
  assign hs_out    = r_hs;
  assign vs_out    = r_vs;
  assign de_out    = r_de;
  assign pix_cnt   = r_pix;
  assign line_cnt  = r_line;
  assign line_len  = r_len;
  assign frame_stb = r_stb;

endmodule
